inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 784, meaning pixel words per image and the address stride.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning scores scanned per image (2..16).
REQ-003 SHALL have parameter NUM_IMAGES, default 100, meaning images per run (1..65535).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 25, meaning cycles waited after each address change (>=1).
REQ-005 SHALL have parameter SCORE_W, default 64, meaning score width (unsigned).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have ports start (input, 1, run request pulse) and abort (input, 1, synchronous run cancel).
REQ-009 SHALL have port addr, output, 32, meaning the image base address fed to the memory reader.
REQ-010 SHALL have ports score_sel (output, 4, class index) and score (input, SCORE_W, selected score, combinational from score_sel).
REQ-011 SHALL have ports image_idx (output, 16, current image) and label (input, 4, label of image_idx, combinational).
REQ-012 SHALL have outputs busy (1), result_valid (1), classified (4), correct (1), correct_count (16) and done (1).

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SCAN, REPORT, DONE.
REQ-014 SHALL, in IDLE with start=1, clear image_idx, addr and correct_count, and enter SETTLE next cycle; start SHALL be ignored in every other state.
REQ-015 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles, then enter SCAN.
REQ-016 SHALL hold SCAN for exactly NUM_CLASSES cycles, driving score_sel = 0,1,...,NUM_CLASSES-1 and sampling score in the same cycle.
REQ-017 SHALL take argmax with strict greater-than (ties keep the lower index); class 0 initialises the running maximum.
REQ-018 SHALL spend one cycle in REPORT: result_valid=1, classified=argmax, correct=(argmax==label); correct_count increments on the following edge when correct.
REQ-019 SHALL, after REPORT, enter DONE if image_idx==NUM_IMAGES-1; otherwise increment image_idx, add IN_WIDTH to addr (no multiplier), and enter SETTLE.
REQ-020 SHALL take exactly SETTLE_CYCLES+NUM_CLASSES+1 cycles per image.
REQ-021 SHALL pulse done for one cycle in DONE, then return to IDLE, with correct_count and classified held until the next start.
REQ-022 SHALL assert busy in SETTLE, SCAN and REPORT only.
REQ-023 SHALL, when abort=1 in any non-IDLE state, go to IDLE next cycle without done or result_valid; abort beats start and REPORT in the same cycle.
REQ-024 SHALL drive result_valid, correct and done low outside their states, and drive score_sel=0 outside SCAN.
REQ-025 SHALL keep addr equal to image_idx*IN_WIDTH modulo 2^32 at all times.

Reset
REQ-026 SHALL, on rst=1 (asynchronously, including mid-run), force IDLE with addr=0, image_idx=0, score_sel=0, classified=0, correct_count=0, and busy, result_valid, correct and done all 0.
REQ-027 SHALL not pulse done or result_valid on reset release.

Configuration
REQ-028 SHALL gate an optional miss logger with macro INFER_MISS_LOG_EN.
REQ-029 SHALL, with INFER_MISS_LOG_EN defined, add outputs miss_seen (1) and miss_idx (16) that capture the image_idx of the first REPORT where correct=0 in a run; both clear on start and on reset.
REQ-030 SHALL, without INFER_MISS_LOG_EN, omit those ports entirely, with all other behaviour identical.

Verification (NUM_IMAGES=3, SETTLE_CYCLES=4, NUM_CLASSES=10, IN_WIDTH=784)
REQ-031 SHALL cover a full run: start pulse, all labels match -> addr 0,784,1568 in turn; result_valid every 15 cycles; done 1 pulse after the 3rd REPORT; correct_count=3.
REQ-032 SHALL cover a tie: scores[3]=scores[7]=100 and all others 5 -> classified=3.
REQ-033 SHALL cover a miss: image 1 label=2 with argmax 4 -> correct=0 on that REPORT; correct_count=2; with INFER_MISS_LOG_EN, miss_seen=1 and miss_idx=1.
REQ-034 SHALL cover abort in SCAN of image 1 -> IDLE next cycle; busy=0; no done; correct_count=1 held.
REQ-035 SHALL cover rst asserted mid-SETTLE -> all outputs at reset values immediately; a start after release begins at addr=0.
REQ-036 SHALL cover start asserted while busy -> ignored; run timing unchanged.

Source files
------------

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Walks a batch of images through an external classifier. For each image it
// presents the image base address, waits for the classifier outputs to settle,
// scans the class scores to find the argmax, and reports the classification
// together with a match against the reference label.
//
// Per image: SETTLE_CYCLES (settle) + NUM_CLASSES (scan) + 1 (report) cycles.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous active-high reset
//   start          : run request pulse (honoured in IDLE only)
//   abort          : synchronous run cancel (any non-IDLE state)
//   addr           : image base address, always image_idx * IN_WIDTH
//   score_sel      : class index being scanned (0 outside SCAN)
//   score          : score of class score_sel (combinational from score_sel)
//   image_idx      : current image number
//   label          : reference label of image_idx (combinational)
//   busy           : high in SETTLE, SCAN and REPORT
//   result_valid   : one-cycle strobe in REPORT
//   classified     : argmax of the last scan, held until the next scan
//   correct        : classified == label, valid with result_valid
//   correct_count  : number of correctly classified images this run
//   done           : one-cycle pulse after the last image
//
// Optional feature, enabled by defining INFER_MISS_LOG_EN:
//   miss_seen      : a misclassification occurred in the current run
//   miss_idx       : image_idx of the first misclassification
// -----------------------------------------------------------------------------
module inference_sequencer #(
    parameter int IN_WIDTH      = 784,
    parameter int NUM_CLASSES   = 10,
    parameter int NUM_IMAGES    = 100,
    parameter int SETTLE_CYCLES = 25,
    parameter int SCORE_W       = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        addr,
    output logic [3:0]         score_sel,
    input  logic [SCORE_W-1:0] score,
    output logic [15:0]        image_idx,
    input  logic [3:0]         label,
    output logic               busy,
    output logic               result_valid,
    output logic [3:0]         classified,
    output logic               correct,
    output logic [15:0]        correct_count,
`ifdef INFER_MISS_LOG_EN
    output logic               miss_seen,
    output logic [15:0]        miss_idx,
`endif
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SCAN   = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [31:0]        cnt_q,       cnt_d;
    logic [31:0]        addr_q,      addr_d;
    logic [15:0]        idx_q,       idx_d;
    logic [SCORE_W-1:0] best_val_q,  best_val_d;
    logic [3:0]         best_idx_q,  best_idx_d;
    logic [15:0]        cc_q,        cc_d;
    logic               miss_seen_q, miss_seen_d;
    logic [15:0]        miss_idx_q,  miss_idx_d;

    logic abort_act_s;
    logic match_s;

    // An abort only cancels an active run; in IDLE it has no effect.
    assign abort_act_s = abort && (state_q != IDLE);
    assign match_s     = (best_idx_q == label);

    // Output decode from the registered state; abort suppresses report and done.
    assign busy          = (state_q == SETTLE) || (state_q == SCAN) || (state_q == REPORT);
    assign result_valid  = (state_q == REPORT) && !abort;
    assign correct       = (state_q == REPORT) && !abort && match_s;
    assign done          = (state_q == DONE) && !abort;
    assign score_sel     = (state_q == SCAN) ? cnt_q[3:0] : 4'd0;
    assign addr          = addr_q;
    assign image_idx     = idx_q;
    assign classified    = best_idx_q;
    assign correct_count = cc_q;

`ifdef INFER_MISS_LOG_EN
    assign miss_seen = miss_seen_q;
    assign miss_idx  = miss_idx_q;
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        cc_d        = cc_q;
        miss_seen_d = miss_seen_q;
        miss_idx_d  = miss_idx_q;

        if (abort_act_s) begin
            state_d = IDLE;
            cnt_d   = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = SETTLE;
                        cnt_d       = 32'd0;
                        addr_d      = 32'd0;
                        idx_d       = 16'd0;
                        cc_d        = 16'd0;
                        miss_seen_d = 1'b0;
                        miss_idx_d  = 16'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                        state_d = SCAN;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                SCAN: begin
                    // Class 0 seeds the maximum; strict > keeps the lower index on ties.
                    if ((cnt_q == 32'd0) || (score > best_val_q)) begin
                        best_val_d = score;
                        best_idx_d = cnt_q[3:0];
                    end else begin
                        best_val_d = best_val_q;
                    end
                    if (cnt_q == 32'(NUM_CLASSES - 1)) begin
                        state_d = REPORT;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                REPORT: begin
                    if (match_s) begin
                        cc_d = cc_q + 16'd1;
                    end else if (!miss_seen_q) begin
                        miss_seen_d = 1'b1;
                        miss_idx_d  = idx_q;
                    end else begin
                        cc_d = cc_q;
                    end
                    if (idx_q == 16'(NUM_IMAGES - 1)) begin
                        state_d = DONE;
                    end else begin
                        // Running sum keeps addr == image_idx * IN_WIDTH without a multiplier.
                        state_d = SETTLE;
                        cnt_d   = 32'd0;
                        idx_d   = idx_q + 16'd1;
                        addr_d  = addr_q + 32'(IN_WIDTH);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 32'd0;
            addr_q      <= 32'd0;
            idx_q       <= 16'd0;
            best_val_q  <= '0;
            best_idx_q  <= 4'd0;
            cc_q        <= 16'd0;
            miss_seen_q <= 1'b0;
            miss_idx_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            cc_q        <= cc_d;
            miss_seen_q <= miss_seen_d;
            miss_idx_q  <= miss_idx_d;
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inference_sequencer
//
// Directed bench for inference_sequencer with NUM_IMAGES=3, SETTLE_CYCLES=4,
// NUM_CLASSES=10, IN_WIDTH=784. Score and label tables are driven by the bench;
// the expected per-cycle timeline (15 cycles per image) and the expected
// argmax/match results are written out by hand for each data set.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

    localparam int NI = 3;
    localparam int SC = 4;
    localparam int NC = 10;
    localparam int IW = 784;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] addr;
    logic [3:0]  score_sel;
    logic [63:0] score;
    logic [15:0] image_idx;
    logic [3:0]  label;
    logic        busy;
    logic        result_valid;
    logic [3:0]  classified;
    logic        correct;
    logic [15:0] correct_count;
    logic        done;
`ifdef INFER_MISS_LOG_EN
    logic        miss_seen;
    logic [15:0] miss_idx;
`endif

    // Score table: 16 slots per image, image i at [16*i .. 16*i+15].
    logic [63:0] sc [0:63];
    logic [3:0]  lb [0:3];
    int          exp_cls [0:2];
    int          exp_cor [0:2];

    int total;
    int bad;

    inference_sequencer #(
        .IN_WIDTH     (IW),
        .NUM_CLASSES  (NC),
        .NUM_IMAGES   (NI),
        .SETTLE_CYCLES(SC),
        .SCORE_W      (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .addr         (addr),
        .score_sel    (score_sel),
        .score        (score),
        .image_idx    (image_idx),
        .label        (label),
        .busy         (busy),
        .result_valid (result_valid),
        .classified   (classified),
        .correct      (correct),
        .correct_count(correct_count),
`ifdef INFER_MISS_LOG_EN
        .miss_seen    (miss_seen),
        .miss_idx     (miss_idx),
`endif
        .done         (done)
    );

    assign score = sc[{image_idx[1:0], score_sel}];
    assign label = lb[image_idx[1:0]];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Set 0: every image classified correctly, with full-width unsigned scores.
    // Set 1: tie on image 0, miss on image 1, all-equal scores on image 2.
    task automatic load_set(input int s);
        for (int i = 0; i < 64; i++) sc[i] = 64'd0;
        if (s == 0) begin
            for (int c = 0; c < NC; c++) sc[c] = 64'd10;
            sc[6] = 64'd50;
            for (int c = 0; c < NC; c++) sc[16 + c] = 64'd1;
            sc[18] = 64'h8000_0000_0000_0000;
            sc[21] = 64'h7FFF_FFFF_FFFF_FFFF;
            sc[32] = 64'hFFFF_FFFF_FFFF_FFFE;
            sc[41] = 64'hFFFF_FFFF_FFFF_FFFF;
            lb[0] = 4'd6; lb[1] = 4'd2; lb[2] = 4'd9; lb[3] = 4'd0;
            exp_cls[0] = 6; exp_cls[1] = 2; exp_cls[2] = 9;
            exp_cor[0] = 1; exp_cor[1] = 1; exp_cor[2] = 1;
        end else begin
            for (int c = 0; c < NC; c++) sc[c] = 64'd5;
            sc[3] = 64'd100;
            sc[7] = 64'd100;
            for (int c = 0; c < NC; c++) sc[16 + c] = 64'd5;
            sc[20] = 64'd200;
            for (int c = 0; c < NC; c++) sc[32 + c] = 64'd7;
            lb[0] = 4'd3; lb[1] = 4'd2; lb[2] = 4'd0; lb[3] = 4'd0;
            exp_cls[0] = 3; exp_cls[1] = 4; exp_cls[2] = 0;
            exp_cor[0] = 1; exp_cor[1] = 0; exp_cor[2] = 1;
        end
    endtask

    // Start a run at the current negedge and follow it for 55 cycles.
    // abort_k / start_k: cycle at whose negedge abort / a stray start is driven.
    task automatic run_check(input int abort_k, input int start_k, input int exp_cc);
        int  img;
        int  ph;
        int  ncor;
        int  e_busy;
        int  e_rv;
        int  e_done;
        int  e_sel;
        ncor  = 0;
        start = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            e_busy = 0; e_rv = 0; e_done = 0; e_sel = 0;
            if (k <= abort_k && k <= 45) begin
                img    = (k - 1) / 15;
                ph     = (k - 1) % 15;
                e_busy = 1;
                e_rv   = (ph == 14) ? 1 : 0;
                e_sel  = (ph >= 4 && ph <= 13) ? ph - 4 : 0;
                check_val($sformatf("addr@%0d", k), addr, 64'(img * IW));
                check_val($sformatf("idx@%0d", k), image_idx, 64'(img));
                if (e_rv == 1) begin
                    check_val($sformatf("cls@%0d", k), classified, 64'(exp_cls[img]));
                    check_val($sformatf("cor@%0d", k), correct, 64'(exp_cor[img]));
                    check_val($sformatf("cc_pre@%0d", k), correct_count, 64'(ncor));
                    ncor = ncor + exp_cor[img];
                end
            end else if (k <= abort_k && k == 46) begin
                e_done = 1;
            end else if (k <= abort_k && k == 47) begin
                check_val("cls_held", classified, 64'(exp_cls[2]));
                check_val("addr_held", addr, 64'(2 * IW));
            end else begin
                e_done = 0;
            end
            check_val($sformatf("busy@%0d", k), busy, 64'(e_busy));
            check_val($sformatf("rv@%0d", k), result_valid, 64'(e_rv));
            check_val($sformatf("done@%0d", k), done, 64'(e_done));
            check_val($sformatf("sel@%0d", k), score_sel, 64'(e_sel));
            if (k == start_k) start = 1'b1;
            if (k == start_k + 1) start = 1'b0;
            if (k == abort_k) abort = 1'b1;
            if (k == abort_k + 1) abort = 1'b0;
        end
        check_val("cc_final", correct_count, 64'(exp_cc));
    endtask

    // Reset checks shared by power-up and mid-run reset.
    task automatic check_reset_state(input string tag);
        check_val({tag, "_addr"}, addr, 64'd0);
        check_val({tag, "_idx"}, image_idx, 64'd0);
        check_val({tag, "_sel"}, score_sel, 64'd0);
        check_val({tag, "_cls"}, classified, 64'd0);
        check_val({tag, "_cc"}, correct_count, 64'd0);
        check_val({tag, "_busy"}, busy, 64'd0);
        check_val({tag, "_rv"}, result_valid, 64'd0);
        check_val({tag, "_cor"}, correct, 64'd0);
        check_val({tag, "_done"}, done, 64'd0);
`ifdef INFER_MISS_LOG_EN
        check_val({tag, "_mseen"}, miss_seen, 64'd0);
        check_val({tag, "_midx"}, miss_idx, 64'd0);
`endif
    endtask

    // Main directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        load_set(0);
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("rel_rv", result_valid, 64'd0);
            check_val("rel_done", done, 64'd0);
        end

        // Full run, all correct, stray start while busy at cycle 20.
        run_check(1000, 20, 3);

        // Tie, miss and all-equal argmax.
        load_set(1);
        run_check(1000, 0, 2);
`ifdef INFER_MISS_LOG_EN
        check_val("miss_seen", miss_seen, 64'd1);
        check_val("miss_idx", miss_idx, 64'd1);
`endif

        // Abort during the scan of image 1.
        load_set(0);
        run_check(22, 0, 1);
`ifdef INFER_MISS_LOG_EN
        check_val("miss_clr", miss_seen, 64'd0);
`endif

        // Asynchronous reset in the middle of SETTLE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("pre_rst_busy", busy, 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("rel2_rv", result_valid, 64'd0);
            check_val("rel2_done", done, 64'd0);
            check_val("rel2_busy", busy, 64'd0);
        end
        run_check(1000, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
